// File: rtl/line_clear_engine.sv
// Multi-cycle line-clear engine: removes every full row in one pass and compacts the board downward.
// Optional LINE_CLEAR_SCORE_EN adds saturating total_lines and score accumulators.
module line_clear_engine #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int TYPE_W  = 3,
    parameter int CELL_W  = TYPE_W + 1,
    parameter int CNT_W   = $clog2(BOARD_H + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [BOARD_H*BOARD_W*CELL_W-1:0]   board_in,
    output logic                                busy,
    output logic                                done,
    output logic [BOARD_H*BOARD_W*CELL_W-1:0]   board_out,
    output logic [CNT_W-1:0]                    lines_cleared,
    output logic [BOARD_H-1:0]                  row_mask
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]                         total_lines,
    output logic [23:0]                         score
`endif
);

    localparam int ROW_W = BOARD_W * CELL_W;
    localparam int BRD_W = BOARD_H * ROW_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPACT = 2'd1;
    localparam logic [1:0] S_FINISH  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [BRD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BOARD_H-1:0] mask_q, mask_d;
    logic [BRD_W-1:0]   board_out_q, board_out_d;
    logic [CNT_W-1:0]   lines_q, lines_d;
    logic [BOARD_H-1:0] row_mask_q, row_mask_d;

    logic [ROW_W-1:0]   row_rd;
    logic               row_full;
    logic [BRD_W-1:0]   work_fin;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] total_q, total_d;
    logic [23:0] score_q, score_d;
    logic [23:0] points;
    logic [16:0] total_sum;
    logic [24:0] score_sum;
`endif

    always_comb begin
        row_rd   = work_q[int'(rd_q)*ROW_W +: ROW_W];
        row_full = 1'b1;
        for (int unsigned c = 0; c < BOARD_W; c++) begin
            row_full = row_full & row_rd[c*CELL_W];
        end
        // Rows at or above the final write pointer are stale copies and get blanked.
        work_fin = work_q;
        for (int unsigned r = 0; r < BOARD_H; r++) begin
            if (CNT_W'(r) >= wr_q) begin
                work_fin[r*ROW_W +: ROW_W] = '0;
            end
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    always_comb begin
        case (cnt_q)
            CNT_W'(0): points = 24'd0;
            CNT_W'(1): points = 24'd100;
            CNT_W'(2): points = 24'd300;
            CNT_W'(3): points = 24'd500;
            default:   points = 24'd800;
        endcase
        total_sum = {1'b0, total_q} + 17'(cnt_q);
        score_sum = {1'b0, score_q} + {1'b0, points};
    end
`endif

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        board_out_d = board_out_q;
        lines_d     = lines_q;
        row_mask_d  = row_mask_q;
`ifdef LINE_CLEAR_SCORE_EN
        total_d     = total_q;
        score_d     = score_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = board_in;
                    rd_d    = '0;
                    wr_d    = '0;
                    cnt_d   = '0;
                    mask_d  = '0;
                    state_d = S_COMPACT;
                end
            end
            S_COMPACT: begin
                // wr never passes rd, so row rd still holds its original content here.
                if (row_full) begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    mask_d[rd_q] = 1'b1;
                end else begin
                    work_d[int'(wr_q)*ROW_W +: ROW_W] = row_rd;
                    wr_d = wr_q + CNT_W'(1);
                end
                if (rd_q == CNT_W'(BOARD_H - 1)) begin
                    rd_d    = '0;
                    state_d = S_FINISH;
                end else begin
                    rd_d = rd_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                work_d      = work_fin;
                board_out_d = work_fin;
                lines_d     = cnt_q;
                row_mask_d  = mask_q;
`ifdef LINE_CLEAR_SCORE_EN
                total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
                score_d = score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
`endif
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            board_out_q <= '0;
            lines_q     <= '0;
            row_mask_q  <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            total_q     <= '0;
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            board_out_q <= board_out_d;
            lines_q     <= lines_d;
            row_mask_q  <= row_mask_d;
`ifdef LINE_CLEAR_SCORE_EN
            total_q     <= total_d;
            score_q     <= score_d;
`endif
        end
    end

    assign busy          = (state_q == S_COMPACT) || (state_q == S_FINISH);
    assign done          = (state_q == S_DONE);
    assign board_out     = board_out_q;
    assign lines_cleared = lines_q;
    assign row_mask      = row_mask_q;
`ifdef LINE_CLEAR_SCORE_EN
    assign total_lines   = total_q;
    assign score         = score_q;
`endif

endmodule
